// File: rtl/ccc_lock_reset_ctrl.sv
// -----------------------------------------------------------------------------
// ccc_lock_reset_ctrl
//
// Reset sequencer for fabric logic that is clocked from the CCC global outputs.
// Runs from the free-running RC oscillator, so it keeps sequencing while the
// PLL is unlocked.
//
// Sequence:
//   1. Hold fabric and peripheral resets while the PLL is unlocked.
//   2. Require LOCK to stay high for LOCK_FILTER_CYCLES consecutive cycles.
//   3. Release FAB_RESET, then wait RELEASE_GAP cycles.
//   4. Wait (without timeout) for INIT_DONE, then release PERIPH_RESET and
//      raise READY.
//   Any lock loss after FAB_RESET has been released re-asserts both resets,
//   pulses LOCK_LOST and bumps a saturating loss counter.
//
// Ports:
//   CLK          in   free-running clock (RCOSC_25_50MHZ)
//   RESET        in   synchronous active-high reset
//   LOCK         in   CCC PLL lock, asynchronous to CLK
//   INIT_DONE    in   MSS/system init complete, asynchronous to CLK
//   CLEAR_COUNT  in   synchronous clear of LOSS_COUNT
//   FAB_RESET    out  active-high reset for fabric logic
//   PERIPH_RESET out  active-high reset for fabric peripherals
//   READY        out  high only while the sequence is complete (S_RUN)
//   LOCK_LOST    out  one-cycle pulse for each counted lock loss
//   LOSS_COUNT   out  saturating lock-loss count (8 bits)
//   STATE        out  current FSM state encoding, for debug
//
// Every output is a flop; nothing from an input reaches an output without
// passing through at least one register.
// -----------------------------------------------------------------------------
module ccc_lock_reset_ctrl #(
    parameter int SYNC_STAGES        = 2,     // 2..4
    parameter int LOCK_FILTER_CYCLES = 1024,  // 2..65535
    parameter int RELEASE_GAP        = 16     // 1..255
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       LOCK,
    input  logic       INIT_DONE,
    input  logic       CLEAR_COUNT,
    output logic       FAB_RESET,
    output logic       PERIPH_RESET,
    output logic       READY,
    output logic       LOCK_LOST,
    output logic [7:0] LOSS_COUNT,
    output logic [2:0] STATE
);

    // -------------------------------------------------------------------------
    // State encodings. Codes 5..7 are unreachable but decode to S_HOLD.
    // -------------------------------------------------------------------------
    localparam logic [2:0] S_HOLD      = 3'd0;
    localparam logic [2:0] S_FILTER    = 3'd1;
    localparam logic [2:0] S_REL_FAB   = 3'd2;
    localparam logic [2:0] S_WAIT_INIT = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;

    // Terminal counts for the lock filter and the release gap.
    localparam logic [15:0] FILT_LAST = 16'(LOCK_FILTER_CYCLES - 1);
    localparam logic [7:0]  GAP_LAST  = 8'(RELEASE_GAP - 1);

    // -------------------------------------------------------------------------
    // Input synchronizers. Bit 0 samples the raw input; the top bit is the
    // synchronized value used by the FSM.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] lock_sync;
    logic [SYNC_STAGES-1:0] init_sync;
    logic                   lock_s;
    logic                   init_s;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            lock_sync <= '0;
            init_sync <= '0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], LOCK};
            init_sync <= {init_sync[SYNC_STAGES-2:0], INIT_DONE};
        end
    end

    assign lock_s = lock_sync[SYNC_STAGES-1];
    assign init_s = init_sync[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // FSM state and counters
    // -------------------------------------------------------------------------
    logic [2:0]  state;
    logic [2:0]  next_state;
    logic [15:0] filt_cnt;
    logic [7:0]  gap_cnt;
    logic        loss;

    // A loss only counts once FAB_RESET has been released; dropping lock
    // while still filtering just restarts the filter.
    assign loss = ~lock_s & ((state == S_REL_FAB) |
                             (state == S_WAIT_INIT) |
                             (state == S_RUN));

    // Process 1: state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_HOLD;
        end else begin
            state <= next_state;
        end
    end

    // Filter and gap counters run only while their state persists, so each
    // starts from zero on entry to its state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            filt_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            if ((state == S_FILTER) && (next_state == S_FILTER)) begin
                filt_cnt <= filt_cnt + 16'd1;
            end else begin
                filt_cnt <= '0;
            end
            if ((state == S_REL_FAB) && (next_state == S_REL_FAB)) begin
                gap_cnt <= gap_cnt + 8'd1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    // Process 2: next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_HOLD: begin
                if (lock_s) begin
                    next_state = S_FILTER;
                end
            end
            S_FILTER: begin
                if (!lock_s) begin
                    next_state = S_HOLD;
                end else if (filt_cnt == FILT_LAST) begin
                    next_state = S_REL_FAB;
                end
            end
            S_REL_FAB: begin
                if (!lock_s) begin
                    next_state = S_HOLD;
                end else if (gap_cnt == GAP_LAST) begin
                    next_state = S_WAIT_INIT;
                end
            end
            S_WAIT_INIT: begin
                if (!lock_s) begin
                    next_state = S_HOLD;
                end else if (init_s) begin
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                // init_s is deliberately ignored here.
                if (!lock_s) begin
                    next_state = S_HOLD;
                end
            end
            default: begin
                next_state = S_HOLD;
            end
        endcase
    end

    // Process 3: output logic. Outputs are decoded from next_state and then
    // registered, so they change on the same edge as the state they describe.
    logic       fab_reset_d;
    logic       periph_reset_d;
    logic       ready_d;
    logic       lock_lost_d;
    logic [7:0] count_base;
    logic [7:0] loss_count_d;

    always_comb begin
        fab_reset_d    = 1'b1;
        periph_reset_d = 1'b1;
        ready_d        = 1'b0;
        lock_lost_d    = loss;
        count_base     = CLEAR_COUNT ? 8'd0 : LOSS_COUNT;
        loss_count_d   = count_base;

        case (next_state)
            S_REL_FAB, S_WAIT_INIT: begin
                fab_reset_d = 1'b0;
            end
            S_RUN: begin
                fab_reset_d    = 1'b0;
                periph_reset_d = 1'b0;
                ready_d        = 1'b1;
            end
            default: begin
                fab_reset_d    = 1'b1;
                periph_reset_d = 1'b1;
            end
        endcase

        // Clear is applied before the increment, so clear + loss gives 1.
        if (loss && (count_base != 8'hFF)) begin
            loss_count_d = count_base + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            FAB_RESET    <= 1'b1;
            PERIPH_RESET <= 1'b1;
            READY        <= 1'b0;
            LOCK_LOST    <= 1'b0;
            LOSS_COUNT   <= 8'd0;
        end else begin
            FAB_RESET    <= fab_reset_d;
            PERIPH_RESET <= periph_reset_d;
            READY        <= ready_d;
            LOCK_LOST    <= lock_lost_d;
            LOSS_COUNT   <= loss_count_d;
        end
    end

    assign STATE = state;

endmodule

// File: tb/tb_ccc_lock_reset_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ccc_lock_reset_ctrl
//
// Bench for ccc_lock_reset_ctrl with SYNC_STAGES=2, LOCK_FILTER_CYCLES=8,
// RELEASE_GAP=4. Stimulus is a table of per-cycle records built up front from
// the documented edge timing; each record's expected outputs are pushed to
// exp_q when it is driven and popped when the outputs are sampled after the
// edge. A final hand-written sequence measures the lock-to-READY latency with
// a bounded wait.
//
// Edge numbering inside each sequence: k=0 is the first edge that samples the
// new LOCK value (edge A). With these parameters, starting from S_HOLD with a
// clean synchronizer:
//   k 0..1  S_HOLD, k 2..9 S_FILTER, k 10..13 S_REL_FAB (FAB_RESET low),
//   k 14    S_WAIT_INIT, k 15 S_RUN (when INIT_DONE is already high).
// -----------------------------------------------------------------------------
module tb_ccc_lock_reset_ctrl;

  localparam int SYNC_STAGES        = 2;
  localparam int LOCK_FILTER_CYCLES = 8;
  localparam int RELEASE_GAP        = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst;
  logic       lock;
  logic       init_done;
  logic       clear_count;
  logic       fab_reset;
  logic       periph_reset;
  logic       ready;
  logic       lock_lost;
  logic [7:0] loss_count;
  logic [2:0] state;

  always #5 clk = ~clk;

  ccc_lock_reset_ctrl #(
    .SYNC_STAGES        (SYNC_STAGES),
    .LOCK_FILTER_CYCLES (LOCK_FILTER_CYCLES),
    .RELEASE_GAP        (RELEASE_GAP)
  ) dut (
    .CLK          (clk),
    .RESET        (rst),
    .LOCK         (lock),
    .INIT_DONE    (init_done),
    .CLEAR_COUNT  (clear_count),
    .FAB_RESET    (fab_reset),
    .PERIPH_RESET (periph_reset),
    .READY        (ready),
    .LOCK_LOST    (lock_lost),
    .LOSS_COUNT   (loss_count),
    .STATE        (state)
  );

  // ---------------------------------------------------------------------------
  // Vector table and scoreboard
  // expected packing: {fab, periph, ready, lost, count[7:0], state[2:0]}
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        rst;
    logic        lock;
    logic        init;
    logic        clr;
    logic [14:0] exp;
    string       tag;
  } vec_t;

  vec_t        vecs[$];
  logic [14:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic int sat(input int x);
    return (x > 255) ? 255 : x;
  endfunction

  task automatic add_vec(input logic rst_i, input logic lock_i, input logic init_i,
                         input logic clr_i, input logic fab, input logic periph,
                         input logic rdy, input logic lost, input logic [7:0] cnt,
                         input logic [2:0] st, input string tag);
    vec_t v;
    v.rst  = rst_i;
    v.lock = lock_i;
    v.init = init_i;
    v.clr  = clr_i;
    v.exp  = {fab, periph, rdy, lost, cnt, st};
    v.tag  = tag;
    vecs.push_back(v);
  endtask

  // Full lock sequence from S_HOLD. INIT_DONE is driven high from k=init_k
  // onward; S_RUN is reached at max(15, init_k+2).
  task automatic add_lock_seq(input int n, input int init_k, input logic [7:0] cnt,
                              input string tag);
    int         run_k;
    logic [2:0] st;
    run_k = (init_k + 2 > 15) ? init_k + 2 : 15;
    for (int k = 0; k < n; k++) begin
      if (k < 2)           st = 3'd0;
      else if (k < 10)     st = 3'd1;
      else if (k < 14)     st = 3'd2;
      else if (k < run_k)  st = 3'd3;
      else                 st = 3'd4;
      add_vec(1'b0, 1'b1, (k >= init_k), 1'b0,
              (k < 10), (k < run_k), (k >= run_k), 1'b0, cnt, st, tag);
    end
  endtask

  // Drop LOCK while in S_RUN: two edges still in S_RUN, then the loss edge.
  task automatic add_drop_from_run(input logic [7:0] cnt_before, input string tag);
    add_vec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, cnt_before, 3'd4, tag);
    add_vec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, cnt_before, 3'd4, tag);
    add_vec(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
            8'(sat(int'(cnt_before) + 1)), 3'd0, tag);
  endtask

  // Lock, reach S_REL_FAB at k=10, drop LOCK at k=11; loss counted at k=13.
  task automatic add_rel_loss(input logic [7:0] cnt_before, input logic clr_last,
                              input string tag);
    logic [2:0] st;
    logic [7:0] cnt_after;
    for (int k = 0; k <= 10; k++) begin
      if (k < 2)       st = 3'd0;
      else if (k < 10) st = 3'd1;
      else             st = 3'd2;
      add_vec(1'b0, 1'b1, 1'b1, 1'b0, (k < 10), 1'b1, 1'b0, 1'b0, cnt_before, st, tag);
    end
    add_vec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, cnt_before, 3'd2, tag);
    add_vec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, cnt_before, 3'd2, tag);
    cnt_after = clr_last ? 8'd1 : 8'(sat(int'(cnt_before) + 1));
    add_vec(1'b0, 1'b0, 1'b1, clr_last, 1'b1, 1'b1, 1'b0, 1'b1, cnt_after, 3'd0, tag);
  endtask

  // ---------------------------------------------------------------------------
  // Driver / checker
  // ---------------------------------------------------------------------------
  task automatic drive_vec(input vec_t v);
    rst         = v.rst;
    lock        = v.lock;
    init_done   = v.init;
    clear_count = v.clr;
    exp_q.push_back(v.exp);
  endtask

  task automatic check_out(input string tag, input int idx);
    logic [14:0] got;
    logic [14:0] want;
    got = {fab_reset, periph_reset, ready, lock_lost, loss_count, state};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s[%0d]: scoreboard empty, got %h", tag, idx, got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s[%0d]: got fab=%0b per=%0b rdy=%0b lost=%0b cnt=%0d st=%0d want fab=%0b per=%0b rdy=%0b lost=%0b cnt=%0d st=%0d",
                 tag, idx, got[14], got[13], got[12], got[11], got[10:3], got[2:0],
                 want[14], want[13], want[12], want[11], want[10:3], want[2:0]);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test
  // ---------------------------------------------------------------------------
  initial begin
    int  edges;
    bit  done;

    rst         = 1'b1;
    lock        = 1'b0;
    init_done   = 1'b0;
    clear_count = 1'b0;

    // Reset state.
    for (int i = 0; i < 3; i++)
      add_vec(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 3'd0, "reset");

    // Basic bring-up: FAB_RESET falls at k=10, READY at k=15.
    add_lock_seq(18, 0, 8'd0, "bringup");

    // Lock loss in S_RUN, then full re-lock with INIT_DONE low until 20 cycles
    // after FAB_RESET release (rises before k=31 -> S_RUN at k=33).
    add_drop_from_run(8'd0, "run_loss");
    add_lock_seq(36, 31, 8'd1, "init_wait");

    // Synchronous reset in S_RUN clears count, no LOCK_LOST pulse.
    add_vec(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 3'd0, "mid_reset");
    add_vec(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 3'd0, "post_reset");

    // Glitch: high 5, low 3 -> filter aborts without counting a loss.
    for (int g = 0; g < 8; g++)
      add_vec(1'b0, (g < 5), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,
              ((g >= 2) && (g <= 6)) ? 3'd1 : 3'd0, "glitch");
    add_lock_seq(18, 0, 8'd0, "after_glitch");

    // Saturation: one loss from S_RUN, then 256 losses from S_REL_FAB.
    add_drop_from_run(8'd0, "loss1");
    for (int i = 0; i < 256; i++)
      add_rel_loss(8'(sat(1 + i)), 1'b0, "sat");

    // Clear in the same cycle as a loss gives 1; clear alone gives 0.
    add_rel_loss(8'd255, 1'b1, "clr_loss");
    add_vec(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 3'd0, "clr_only");

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive_vec(vecs[i]);
      @(posedge clk);
      #1;
      check_out(vecs[i].tag, i);
    end

    // Lock-to-READY latency: READY must first be seen on the 16th edge.
    @(negedge clk);
    lock        = 1'b1;
    init_done   = 1'b1;
    clear_count = 1'b0;
    edges       = 0;
    done        = 1'b0;
    while (!done && edges < 64) begin
      @(posedge clk);
      #1;
      edges++;
      if (ready) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL ready_latency: READY not seen within %0d edges, required 16", edges);
    end else if (edges != 16) begin
      n_fail++;
      $display("FAIL ready_latency: READY after %0d edges, required 16", edges);
    end
    n_checks++;
    if (fab_reset !== 1'b0 || periph_reset !== 1'b0 || loss_count !== 8'd0) begin
      n_fail++;
      $display("FAIL run_outputs: fab=%0b per=%0b cnt=%0d, required fab=0 per=0 cnt=0",
               fab_reset, periph_reset, loss_count);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ccc_lock_reset_ctrl.md
# ccc_lock_reset_ctrl

Reset sequencer that sits directly downstream of the fabric CCC: it consumes the CCC `LOCK` output and the MSS/system init-done indication, and produces sequenced, synchronous reset releases for fabric logic clocked from the CCC global outputs. It filters lock glitches, releases fabric reset before peripheral reset, and re-asserts both on lock loss. It also keeps a saturating count of lock-loss events for the firmware status register. It is clocked from the free-running `RCOSC_25_50MHZ` oscillator, never from a CCC output, so it keeps running while the PLL is unlocked.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth for `LOCK` and `INIT_DONE`; legal range 2–4.
- `LOCK_FILTER_CYCLES`, 1024: consecutive cycles `lock_s` must stay high before fabric reset release; legal range 2–65535; 16-bit counter.
- `RELEASE_GAP`, 16: cycles between fabric reset release and the start of the init wait; legal range 1–255.

Ports:
- `CLK` in 1: free-running clock, driven by `RCOSC_25_50MHZ`.
- `RESET` in 1: synchronous, active-high reset.
- `LOCK` in 1: CCC PLL lock; asynchronous to `CLK`.
- `INIT_DONE` in 1: MSS/system init complete; asynchronous to `CLK`.
- `CLEAR_COUNT` in 1: synchronous; clears `LOSS_COUNT`.
- `FAB_RESET` out 1: active-high reset for fabric logic.
- `PERIPH_RESET` out 1: active-high reset for fabric peripherals (APB slaves, MAC glue).
- `READY` out 1: high in `S_RUN` only.
- `LOCK_LOST` out 1: one-cycle pulse on a counted lock loss.
- `LOSS_COUNT` out 8: saturating lock-loss count.
- `STATE` out 3: FSM encoding, for debug.

## Operation
- `LOCK` and `INIT_DONE` each pass through `SYNC_STAGES` flops to produce `lock_s` and `init_s`. Chain reset value is 0.
- FSM encodings: `S_HOLD`=0, `S_FILTER`=1, `S_REL_FAB`=2, `S_WAIT_INIT`=3, `S_RUN`=4. Codes 5–7 go to `S_HOLD`.
- `S_HOLD`: both resets high. `filt_cnt`=0. Go to `S_FILTER` when `lock_s`=1.
- `S_FILTER`: `filt_cnt` increments each cycle.
  - If `lock_s`=0, go to `S_HOLD`. This is not counted as a loss.
  - If `filt_cnt`==`LOCK_FILTER_CYCLES`-1 and `lock_s`=1, go to `S_REL_FAB`.
- `S_REL_FAB`: `FAB_RESET` low. `gap_cnt` counts 0..`RELEASE_GAP`-1, then the FSM goes to `S_WAIT_INIT`.
- `S_WAIT_INIT`: `FAB_RESET` low. Go to `S_RUN` when `init_s`=1. There is no timeout.
- `S_RUN`: both resets low, `READY`=1. `init_s` is ignored once in `S_RUN`.
- Lock loss (`lock_s`=0) in `S_REL_FAB`, `S_WAIT_INIT` or `S_RUN`:
  - Next state is `S_HOLD`.
  - `LOCK_LOST` pulses for one cycle.
  - `LOSS_COUNT` increments, saturating at 255.
  - Both resets re-assert and `READY` drops on that same edge.
- `CLEAR_COUNT`=1 sets `LOSS_COUNT` to 0. If a counted loss occurs in the same cycle, the result is 1 (clear, then increment).
- Reset values: `FAB_RESET`=1, `PERIPH_RESET`=1, `READY`=0, `LOCK_LOST`=0, `LOSS_COUNT`=0, `STATE`=0, all counters and sync chains 0.
- `RESET` asserted mid-operation: `S_HOLD` on the next edge, no `LOCK_LOST` pulse, `LOSS_COUNT` cleared.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Let edge A be the first edge at which `LOCK` is sampled high.
  - `lock_s`=1 after edge A+`SYNC_STAGES`-1.
  - `S_FILTER` is entered at edge E0 = A+`SYNC_STAGES`.
- `FAB_RESET` falls at edge E0+`LOCK_FILTER_CYCLES`.
- `S_WAIT_INIT` is entered at edge E0+`LOCK_FILTER_CYCLES`+`RELEASE_GAP`.
- If `init_s` is already 1, `PERIPH_RESET` falls and `READY` rises one edge after `S_WAIT_INIT` is entered.
- Lock-loss response: `LOCK` falling at edge B gives resets high at edge B+`SYNC_STAGES`.
- Lock pulses shorter than `LOCK_FILTER_CYCLES` cycles never release `FAB_RESET`.

## Test plan
- Parameters `SYNC_STAGES`=2, `LOCK_FILTER_CYCLES`=8, `RELEASE_GAP`=4, `INIT_DONE` held high. Raise `LOCK` before edge 0 -> `FAB_RESET` falls at edge 10; `PERIPH_RESET` falls and `READY` rises at edge 15; `LOSS_COUNT`=0.
- `LOCK` high for 5 cycles, low for 3, then high -> no counted loss, `LOSS_COUNT`=0; the filter restarts and `FAB_RESET` falls 10 edges after the final rise.
- In `S_RUN`, drop `LOCK` -> after 2 edges both resets are high, `READY`=0, one `LOCK_LOST` pulse, `LOSS_COUNT`=1; re-lock completes the full sequence again.
- `INIT_DONE` low until 20 cycles after `FAB_RESET` release -> `STATE`=3 throughout the wait; `PERIPH_RESET` falls 3 edges after `INIT_DONE` rises.
- 256 lock losses -> `LOSS_COUNT` saturates at 255. `CLEAR_COUNT` in the same cycle as a loss -> `LOSS_COUNT`=1.
- Assert `RESET` for one cycle in `S_RUN` -> next edge `STATE`=0, both resets high, `LOSS_COUNT`=0, no `LOCK_LOST` pulse.
